// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: memory access size, bus command and
// the buffered store entry.
package store_buffer_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } MEM_SIZE;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } BUS_COMMAND;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
      MEM_SIZE         size;
   } SB_ENTRY;

   // Two addresses fall in the same naturally aligned 32-bit word.
   function automatic logic same_word(input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
      return a[XLEN-1:2] == b[XLEN-1:2];
   endfunction

endpackage

// File: rtl/store_buffer_cam.sv
// Load forwarding search over the occupied store buffer entries; the
// youngest entry in the same word decides between a forward and a stall.
module store_buffer_cam
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  SB_ENTRY                  entries [DEPTH],
   input  logic [$clog2(DEPTH)-1:0] head,
   input  logic [$clog2(DEPTH):0]   count,
   input  logic [XLEN-1:0]          ld_addr,
   input  logic [1:0]               ld_size,
   output logic                     ld_hit,
   output logic                     ld_conflict,
   output logic [XLEN-1:0]          ld_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] idx;
   logic             found;
   logic             exact;
   logic [XLEN-1:0]  fwd_data;

   always_comb begin
      // NOTE: every combinational output gets a default before the loop so no
      // path leaves a variable unassigned, which would infer a latch.
      idx      = '0;
      found    = 1'b0;
      exact    = 1'b0;
      fwd_data = '0;
      // Walk oldest to youngest so the last match is the youngest one.
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PTR_W'(k);
         if ((CNT_W'(k) < count) && same_word(entries[idx].addr, ld_addr)) begin
            found    = 1'b1;
            exact    = (entries[idx].addr == ld_addr) && (entries[idx].size == WORD)
                       && (ld_size == WORD);
            fwd_data = entries[idx].data;
         end
      end
      ld_hit      = found && exact;
      ld_conflict = found && !exact;
      ld_data     = (found && exact) ? fwd_data : '0;
   end

endmodule

// File: rtl/store_buffer.sv
// Circular FIFO of pending stores draining to Dmem from the head entry.
// Load forwarding is built only when STORE_BUF_FWD_EN is defined.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   st_req,
   input  logic [XLEN-1:0]        st_addr,
   input  logic [XLEN-1:0]        st_data,
   input  logic [1:0]             st_size,
   output logic                   st_ack,
   output logic                   dmem_req,
   output logic [XLEN-1:0]        dmem_addr,
   output logic [XLEN-1:0]        dmem_data,
   output logic [1:0]             dmem_size,
   output BUS_COMMAND             dmem_command,
   input  logic                   dmem_grant,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   input  logic [XLEN-1:0]        ld_addr,
   input  logic [1:0]             ld_size,
   output logic                   ld_hit,
   output logic                   ld_conflict,
   output logic [XLEN-1:0]        ld_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   SB_ENTRY          entries [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic             push;
   logic             pop;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // A pop this cycle deliberately does not open a slot for a new store.
   assign st_ack = st_req && !full && !reset;
   assign push   = st_ack;
   assign pop    = !empty && dmem_grant;

   always_ff @(posedge clock) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PTR_ONE;
         if (pop)  head <= head + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // NOTE: entry storage has no reset; occupancy is defined by head/count
   // alone, so stale contents are never observed.
   always_ff @(posedge clock) begin
      if (push) entries[tail] <= '{addr: st_addr, data: st_data, size: MEM_SIZE'(st_size)};
   end

   assign dmem_req     = !empty;
   assign dmem_addr    = entries[head].addr;
   assign dmem_data    = entries[head].data;
   assign dmem_size    = entries[head].size;
   assign dmem_command = dmem_req ? BUS_STORE : BUS_NONE;

`ifdef STORE_BUF_FWD_EN
   store_buffer_cam #(
      .DEPTH(DEPTH)
   ) u_cam (
      .entries    (entries),
      .head       (head),
      .count      (count),
      .ld_addr    (ld_addr),
      .ld_size    (ld_size),
      .ld_hit     (ld_hit),
      .ld_conflict(ld_conflict),
      .ld_data    (ld_data)
   );
`else
   // Without forwarding, any buffered store stalls every load.
   logic unused_ld;
   assign unused_ld   = ^{ld_addr, ld_size};
   assign ld_hit      = 1'b0;
   assign ld_conflict = !empty;
   assign ld_data     = '0;
`endif

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores; power of two, >=2.
REQ-002 SHALL have clock  input  1  system clock; reset reset, synchronous, active-high; clock clock.
REQ-003 SHALL have reset  input  1  synchronous active-high reset.
REQ-004 SHALL have st_req  input  1  store request from store FU (its mem_req).
REQ-005 SHALL have st_addr  input  XLEN  store byte address.
REQ-006 SHALL have st_data  input  XLEN  store data, right-aligned.
REQ-007 SHALL have st_size  input  2  MEM_SIZE (BYTE/HALF/WORD).
REQ-008 SHALL have st_ack  output  1  store accepted this cycle (store FU mem_ack).
REQ-009 SHALL have dmem_req  output  1  head entry valid toward Dmem.
REQ-010 SHALL have dmem_addr, dmem_data  output  XLEN each  head entry address/data.
REQ-011 SHALL have dmem_size  output  2  head entry size; dmem_command output BUS_COMMAND = BUS_STORE when dmem_req, else BUS_NONE.
REQ-012 SHALL have dmem_grant  input  1  Dmem accepted head write this cycle.
REQ-013 SHALL have count  output  $clog2(DEPTH)+1  occupied entries; full, empty  output  1 each.
REQ-014 SHALL have ld_addr  input  XLEN, ld_size  input  2, ld_hit  output  1, ld_conflict  output  1, ld_data  output  XLEN  load forwarding port.

Function
REQ-015 SHALL assert st_ack combinationally iff st_req && !full; pop in the same cycle does not free a slot for acceptance.
REQ-016 SHALL enqueue {st_addr,st_data,st_size} at tail on st_req && st_ack; st_ack SHALL be a single-cycle pulse per accepted store.
REQ-017 SHALL drive dmem_req = !empty, with dmem_addr/data/size from head entry registers (no combinational path from st_* to dmem_*).
REQ-018 SHALL pop head on dmem_req && dmem_grant; dmem_grant while empty SHALL be ignored.
REQ-019 Latency: store accepted in cycle N into empty buffer SHALL appear on dmem_req in cycle N+1.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-021 Head/tail pointers SHALL wrap modulo DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-022 Head outputs SHALL remain stable while dmem_req && !dmem_grant.
REQ-023 Forwarding (combinational): ld_hit=1, ld_data=entry data when youngest valid entry with addr==ld_addr has size==WORD and ld_size==WORD.
REQ-024 ld_conflict=1 when any valid entry shares ld_addr[XLEN-1:2] but REQ-023 does not apply for the youngest such entry; ld_hit and ld_conflict SHALL never both be 1.
REQ-025 An entry popped in the current cycle SHALL still participate in forwarding that cycle; an entry pushed this cycle SHALL NOT.

Reset
REQ-026 On reset: count=0, pointers=0, empty=1, full=0, st_ack=0, dmem_req=0, ld_hit=0, ld_conflict=0, dmem_command=BUS_NONE.
REQ-027 Reset mid-operation SHALL discard all buffered stores; no further dmem_req until a new store is accepted.

Configuration
REQ-028 Macro STORE_BUF_FWD_EN: defined -> REQ-023..025 implemented; undefined -> ld_* ports still present, ld_hit=0, ld_conflict=1 whenever !empty (loads stall on any buffered store), ld_data=0.

Structure
REQ-029 SB_ENTRY struct {addr, data, size} SHALL live in the shared package alongside MEM_SIZE and BUS_COMMAND.
REQ-030 Forwarding search SHALL be sub-module store_buffer_cam, instantiated only under STORE_BUF_FWD_EN.

Verification
REQ-031 Single store: st_req addr=0x100, data=0xDEADBEEF, WORD, grant tied 1 -> st_ack same cycle; next cycle dmem_req=1, addr 0x100, data 0xDEADBEEF; then empty=1.
REQ-032 Full: grant=0, push 5 stores with DEPTH=4 -> first 4 acked, 5th st_ack=0 while full=1; one grant -> 5th acked the following cycle.
REQ-033 Order/wrap: 10 stores addr 0x0..0x24 step 4, random grant -> dmem_addr sequence identical in order, count never >4.
REQ-034 Simultaneous push/pop at count=2 -> count stays 2, popped entry is oldest.
REQ-035 Forwarding (macro on): buffer WORD 0x200=0x11111111 then 0x200=0x22222222; load WORD 0x200 -> ld_hit=1, ld_data=0x22222222; BYTE store 0x201 then load WORD 0x200 -> ld_conflict=1.
REQ-036 Reset with 3 entries pending -> next cycle count=0, dmem_req=0, no write issued.
